// File: rtl/mina_fetch_unit_pkg.sv
// Shared types for the mina instruction fetch front end.
package mina_fetch_unit_pkg;

   typedef logic [31:0] u32_t;

   typedef struct packed {
      u32_t ia_plus_4;
      u32_t ir;
   } id_params_t;

   localparam u32_t IA_STEP = 32'd4;

   function automatic u32_t word_align(input u32_t a);
      return {a[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/mina_fetch_unit_if.sv
// Fetch unit bus bundle: IMEM req/gnt/rvalid, redirect strobe and IF/ID handshake.
interface mina_fetch_unit_if;
   import mina_fetch_unit_pkg::*;

   logic       imem_req;
   u32_t       imem_addr;
   logic       imem_gnt;
   logic       imem_rvalid;
   u32_t       imem_rdata;
   logic       redirect_valid;
   u32_t       redirect_ia;
   logic       id_valid;
   logic       id_ready;
   id_params_t id_params;

   modport master (
      output imem_req, imem_addr, id_valid, id_params,
      input  imem_gnt, imem_rvalid, imem_rdata,
      input  redirect_valid, redirect_ia, id_ready
   );

   modport slave (
      input  imem_req, imem_addr, id_valid, id_params,
      output imem_gnt, imem_rvalid, imem_rdata,
      output redirect_valid, redirect_ia, id_ready
   );

endinterface

// File: rtl/mina_fetch_unit_fifo.sv
// Generic synchronous FIFO with clear; push and pop together are legal when full.
module mina_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push_i,
   input  logic [WIDTH-1:0]           wdata_i,
   input  logic                       pop_i,
   input  logic                       clear_i,
   output logic [WIDTH-1:0]           rdata_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o,
   output logic                       empty_o,
   output logic                       full_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wptr_q;
   logic [AW-1:0]    rptr_q;
   logic [CW-1:0]    cnt_q;
   logic             do_push;
   logic             do_pop;

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == CW'(DEPTH));
   assign count_o = cnt_q;
   assign rdata_o = mem_q[rptr_q];
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else if (clear_i) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         if (do_push) begin
            mem_q[wptr_q] <= wdata_i;
            wptr_q        <= wptr_q + AW'(1);
         end
         if (do_pop) rptr_q <= rptr_q + AW'(1);
         cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/mina_fetch_unit.sv
// Instruction fetch front end: credit-limited IMEM issue, prefetch FIFO,
// redirect with squash of in-flight responses.
module mina_fetch_unit
   import mina_fetch_unit_pkg::*;
#(
   parameter u32_t RESET_IA        = 32'h0000_0000,
   parameter int   FIFO_DEPTH      = 4,
   parameter int   MAX_OUTSTANDING = 2
) (
   input logic               clk,
   input logic               rst_n,
   mina_fetch_unit_if.master fe
);
   localparam int OW = $clog2(MAX_OUTSTANDING+1);
   localparam int CW = $clog2(FIFO_DEPTH+1);

   u32_t          ia_q, ia_d;
   u32_t          resp_ia_q, resp_ia_d;
   logic [OW-1:0] live_q, live_d;
   logic [OW-1:0] stale_q, stale_d;
   logic [CW-1:0] fifo_cnt;
   logic          fifo_empty;
   logic          fifo_full;
   logic          credit_ok;
   logic          room_ok;
   logic          take;
   logic          resp;
   logic          resp_live;
   logic          push;
   logic          pop;
   id_params_t    push_data;
   id_params_t    head;

   // room_ok reserves a FIFO slot for every live request, so pushes never overflow
   assign credit_ok = (32'(live_q) + 32'(stale_q)) < 32'(MAX_OUTSTANDING);
   assign room_ok   = (32'(fifo_cnt) + 32'(live_q)) < 32'(FIFO_DEPTH);

   assign fe.imem_req  = rst_n && !fe.redirect_valid && credit_ok && room_ok;
   assign fe.imem_addr = ia_q;
   assign fe.id_valid  = !fifo_empty && !fe.redirect_valid;
   assign fe.id_params = head;

   assign take      = fe.imem_req && fe.imem_gnt;
   assign resp      = fe.imem_rvalid && (live_q != '0 || stale_q != '0);
   assign resp_live = resp && (stale_q == '0);
   assign push      = resp_live && !fe.redirect_valid;
   assign pop       = fe.id_valid && fe.id_ready;
   assign push_data = '{ia_plus_4: resp_ia_q + IA_STEP, ir: fe.imem_rdata};

   always_comb begin
      ia_d      = ia_q;
      resp_ia_d = resp_ia_q;
      live_d    = live_q;
      stale_d   = stale_q;
      if (fe.redirect_valid) begin
         ia_d      = word_align(fe.redirect_ia);
         resp_ia_d = word_align(fe.redirect_ia);
         stale_d   = stale_q + live_q - OW'(resp);
         live_d    = '0;
      end else begin
         if (take) ia_d = ia_q + IA_STEP;
         if (resp_live) resp_ia_d = resp_ia_q + IA_STEP;
         stale_d = stale_q - OW'(resp && !resp_live);
         live_d  = live_q + OW'(take) - OW'(resp_live);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ia_q      <= RESET_IA;
         resp_ia_q <= RESET_IA;
         live_q    <= '0;
         stale_q   <= '0;
      end else begin
         ia_q      <= ia_d;
         resp_ia_q <= resp_ia_d;
         live_q    <= live_d;
         stale_q   <= stale_d;
      end
   end

   mina_fifo #(
      .WIDTH ($bits(id_params_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .wdata_i (push_data),
      .pop_i   (pop),
      .clear_i (fe.redirect_valid),
      .rdata_o (head),
      .count_o (fifo_cnt),
      .empty_o (fifo_empty),
      .full_o  (fifo_full)
   );

   rvalid_expected: assert property (@(posedge clk) disable iff (!rst_n)
      fe.imem_rvalid |-> (live_q != '0 || stale_q != '0));

   no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      push |-> (!fifo_full || pop));

   stale_bound: assert property (@(posedge clk) disable iff (!rst_n)
      (32'(live_q) + 32'(stale_q)) <= 32'(MAX_OUTSTANDING));

endmodule

// File: tb/tb_mina_fetch_unit.sv
// Directed vector bench for mina_fetch_unit; IMEM slave answers ~addr in grant order.
module tb_mina_fetch_unit;
   import mina_fetch_unit_pkg::*;

   typedef struct {
      logic gnt;
      logic rv;
      logic rdr;
      u32_t rdia;
      logic rdy;
      logic req;
      u32_t addr;
      logic idv;
      u32_t ia4;
      logic zp;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   int   nvec = 0;
   int   nbad = 0;
   u32_t q[$];
   vec_t vt[$];

   always #5 clk = ~clk;

   mina_fetch_unit_if bus();

   mina_fetch_unit #(
      .RESET_IA        (32'h0000_0000),
      .FIFO_DEPTH      (4),
      .MAX_OUTSTANDING (2)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .fe    (bus)
   );

   function automatic vec_t mk(logic g, logic r, logic d, u32_t da, logic y,
                               logic eq, u32_t ea, logic ev, u32_t e4);
      vec_t v;
      v.gnt = g; v.rv = r; v.rdr = d; v.rdia = da; v.rdy = y;
      v.req = eq; v.addr = ea; v.idv = ev; v.ia4 = e4; v.zp = 1'b0;
      return v;
   endfunction

   task automatic idle();
      bus.imem_gnt       = 1'b0;
      bus.imem_rvalid    = 1'b0;
      bus.imem_rdata     = '0;
      bus.redirect_valid = 1'b0;
      bus.redirect_ia    = '0;
      bus.id_ready       = 1'b0;
   endtask

   task automatic check(input string nm, input vec_t v);
      logic ok;
      nvec++;
      ok = (bus.imem_req === v.req) && (bus.imem_addr === v.addr)
           && (bus.id_valid === v.idv);
      if (v.idv)
         ok = ok && (bus.id_params.ia_plus_4 === v.ia4)
                 && (bus.id_params.ir === ~(v.ia4 - 32'd4));
      if (v.zp) ok = ok && (bus.id_params === '0);
      if (!ok) begin
         nbad++;
         $display("FAIL %s: got req=%0b addr=%h idv=%0b params=%h, want req=%0b addr=%h idv=%0b ia4=%h",
                  nm, bus.imem_req, bus.imem_addr, bus.id_valid, bus.id_params,
                  v.req, v.addr, v.idv, v.ia4);
      end
   endtask

   task automatic run(input vec_t v, input string nm);
      logic tk;
      logic rs;
      u32_t ta;
      bus.imem_gnt       = v.gnt;
      bus.redirect_valid = v.rdr;
      bus.redirect_ia    = v.rdia;
      bus.id_ready       = v.rdy;
      if (v.rv && q.size() != 0) begin
         bus.imem_rvalid = 1'b1;
         bus.imem_rdata  = ~q[0];
      end else begin
         bus.imem_rvalid = 1'b0;
         bus.imem_rdata  = '0;
      end
      @(negedge clk);
      check(nm, v);
      tk = bus.imem_req && bus.imem_gnt;
      ta = bus.imem_addr;
      rs = bus.imem_rvalid;
      @(posedge clk);
      #1;
      if (rs) void'(q.pop_front());
      if (tk) q.push_back(ta);
   endtask

   initial begin
      vec_t r;
      rst_n = 1'b0;
      idle();
      // streaming from reset, then IF/ID stall until the FIFO fills
      vt.push_back(mk(1,1,0,0,1, 1,32'h00,0,0));
      vt.push_back(mk(1,1,0,0,1, 1,32'h04,0,0));
      vt.push_back(mk(1,1,0,0,1, 1,32'h08,1,32'h04));
      vt.push_back(mk(1,1,0,0,1, 1,32'h0C,1,32'h08));
      vt.push_back(mk(1,1,0,0,1, 1,32'h10,1,32'h0C));
      vt.push_back(mk(1,1,0,0,0, 1,32'h14,1,32'h10));
      vt.push_back(mk(1,1,0,0,0, 1,32'h18,1,32'h10));
      for (int i = 0; i < 8; i++)
         vt.push_back(mk(1,1,0,0,0, 0,32'h1C,1,32'h10));
      vt.push_back(mk(1,1,0,0,1, 0,32'h1C,1,32'h10));
      vt.push_back(mk(1,1,0,0,1, 1,32'h1C,1,32'h14));
      vt.push_back(mk(1,1,0,0,1, 1,32'h20,1,32'h18));
      vt.push_back(mk(1,1,0,0,1, 1,32'h24,1,32'h1C));
      vt.push_back(mk(1,1,0,0,1, 1,32'h28,1,32'h20));
      vt.push_back(mk(1,1,0,0,1, 1,32'h2C,1,32'h24));
      // redirect with rvalid, then gnt withheld at 0x10
      vt.push_back(mk(1,1,1,32'h10,1, 0,32'h30,0,0));
      for (int i = 0; i < 3; i++)
         vt.push_back(mk(0,1,0,0,1, 1,32'h10,0,0));
      vt.push_back(mk(1,1,0,0,1, 1,32'h10,0,0));
      vt.push_back(mk(1,1,0,0,1, 1,32'h14,0,0));
      vt.push_back(mk(1,1,0,0,1, 1,32'h18,1,32'h14));
      vt.push_back(mk(1,1,0,0,1, 1,32'h1C,1,32'h18));
      vt.push_back(mk(1,1,0,0,1, 1,32'h20,1,32'h1C));
      // 0x20/0x24 in flight, squashed by redirect to 0x100
      vt.push_back(mk(1,0,0,0,1, 1,32'h24,1,32'h20));
      vt.push_back(mk(1,0,0,0,1, 0,32'h28,0,0));
      vt.push_back(mk(1,0,1,32'h103,1, 0,32'h28,0,0));
      vt.push_back(mk(1,1,0,0,1, 0,32'h100,0,0));
      vt.push_back(mk(1,1,0,0,1, 1,32'h100,0,0));
      vt.push_back(mk(1,1,0,0,1, 1,32'h104,0,0));
      vt.push_back(mk(1,0,0,0,1, 1,32'h108,1,32'h104));
      // redirect with rvalid, then back-to-back redirect
      vt.push_back(mk(1,1,1,32'h200,1, 0,32'h10C,0,0));
      vt.push_back(mk(1,0,1,32'h300,1, 0,32'h200,0,0));
      vt.push_back(mk(1,1,0,0,1, 1,32'h300,0,0));
      vt.push_back(mk(1,1,0,0,1, 1,32'h304,0,0));
      vt.push_back(mk(1,1,0,0,1, 1,32'h308,1,32'h304));
      vt.push_back(mk(1,1,0,0,1, 1,32'h30C,1,32'h308));
      // address wrap-around
      vt.push_back(mk(1,1,1,32'hFFFF_FFF8,1, 0,32'h310,0,0));
      vt.push_back(mk(1,1,0,0,1, 1,32'hFFFF_FFF8,0,0));
      vt.push_back(mk(1,1,0,0,1, 1,32'hFFFF_FFFC,0,0));
      vt.push_back(mk(1,1,0,0,1, 1,32'h0000_0000,1,32'hFFFF_FFFC));
      vt.push_back(mk(1,1,0,0,1, 1,32'h0000_0004,1,32'h0000_0000));

      #12;
      r = mk(0,0,0,0,0, 0,32'h0,0,0);
      r.zp = 1'b1;
      check("reset", r);
      @(posedge clk);
      #1 rst_n = 1'b1;

      for (int i = 0; i < vt.size(); i++)
         run(vt[i], $sformatf("vec%0d", i));

      #2 rst_n = 1'b0;
      idle();
      #1 check("rst_mid", r);
      q.delete();
      repeat (2) @(posedge clk);
      #1;
      check("rst_hold", r);
      rst_n = 1'b1;

      run(mk(1,1,0,0,1, 1,32'h00,0,0), "post0");
      run(mk(1,1,0,0,1, 1,32'h04,0,0), "post1");
      run(mk(1,1,0,0,1, 1,32'h08,1,32'h04), "post2");
      run(mk(1,1,0,0,1, 1,32'h0C,1,32'h08), "post3");

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end

endmodule
